// File: rtl/ram_fifo_drain.sv
// Read-side master for the byte-FIFO RAM: drains len bytes into a small output buffer and streams them out.
// Optional starvation abort is compiled in with `define DRAIN_TIMEOUT_EN.
module ram_fifo_drain #(
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 11,
  parameter int BUF_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              mem_rd_en,
  input  logic              mem_empty,
  input  logic [DATA_W-1:0] mem_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_issued;
  logic               r_inflight;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout_err;
  logic [DATA_W-1:0]  r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;

  logic               w_abort;
  logic               w_more;
  logic               w_room;
  logic               w_rd_en;
  logic               w_push;
  logic               w_pop;
  logic               w_drained;

  // Room is judged on occupancy before this cycle's pop plus any read still in flight.
  assign w_more    = (r_issued != r_len) && !w_abort;
  assign w_room    = ((OCC_W+1)'(r_occ) + (OCC_W+1)'(r_inflight)) < (OCC_W+1)'(BUF_DEPTH);
  assign w_rd_en   = (r_state == S_RUN) && w_more && !mem_empty && w_room;
  assign w_push    = r_inflight;
  assign w_pop     = (r_occ != '0) && m_ready;
  assign w_drained = !w_more && !r_inflight && (r_occ == '0);

  assign mem_rd_en   = w_rd_en;
  assign m_valid     = (r_occ != '0);
  assign m_data      = r_buf[r_rd_ptr];
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

`ifdef DRAIN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_abort;
  logic            w_starved;

  assign w_starved = (r_state == S_RUN) && w_more && mem_empty;
  assign w_abort   = r_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_abort  <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_to_cnt <= '0;
      r_abort  <= 1'b0;
    end else if (w_starved) begin
      if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        r_to_cnt <= '0;
        r_abort  <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_issued      <= '0;
      r_inflight    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_issued <= r_issued + LEN_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len         <= len;
            r_issued      <= '0;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
            r_state       <= (len == '0) ? S_FIN : S_RUN;
          end else if (r_done) begin
            r_busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_drained) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state       <= S_IDLE;
          r_done        <= 1'b1;
          r_timeout_err <= w_abort;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_buf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_buf[gi] <= '0;
        end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_buf[gi] <= mem_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_fifo_drain.sv
// Directed bench for ram_fifo_drain: RAM model returns an incrementing byte pattern one cycle after each read.
module tb_ram_fifo_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] len;
  logic        busy, done, timeout_err, mem_rd_en;
  logic        mem_empty;
  logic [7:0]  mem_data = 8'h00;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;

  always #5 clk = ~clk;

  ram_fifo_drain #(
    .DATA_W(8), .LEN_W(11), .BUF_DEPTH(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .mem_rd_en(mem_rd_en), .mem_empty(mem_empty), .mem_data(mem_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: each read observed mid-cycle returns the next pattern byte after the edge.
  logic [7:0] src_byte = 8'h10;
  logic       rd_seen  = 1'b0;
  always @(negedge clk) rd_seen <= mem_rd_en;
  always @(posedge clk) begin
    if (rd_seen) begin
      mem_data <= src_byte;
      src_byte <= src_byte + 8'd1;
    end
  end

  // Stream monitor, sampled mid-cycle.
  logic       clr = 1'b0;
  logic [7:0] got[$];
  int rd_cnt, done_cnt, viol_empty, viol_stable, first_rd, last_rd, first_val;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (clr) begin
      got.delete();
      rd_cnt      <= 0;
      done_cnt    <= 0;
      viol_empty  <= 0;
      viol_stable <= 0;
      first_rd    <= -1;
      last_rd     <= -1;
      first_val   <= -1;
      prev_stall  <= 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (mem_empty) viol_empty <= viol_empty + 1;
        if (first_rd < 0) first_rd <= cyc;
        last_rd <= cyc;
        rd_cnt  <= rd_cnt + 1;
      end
      if (m_valid && first_val < 0) first_val <= cyc;
      if (m_valid && m_ready) got.push_back(m_data);
      if (done) done_cnt <= done_cnt + 1;
      if (prev_stall && (!m_valid || m_data != prev_data)) viol_stable <= viol_stable + 1;
      prev_stall <= m_valid && !m_ready && !rst;
      prev_data  <= m_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [10:0] l);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (!done && k < max) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [7:0] base);
    logic [7:0] e;
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      e = base + 8'(i);
      check({tag, "_byte"}, got[i], e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] base;
    int k;
    rst = 1'b1; start = 1'b0; len = '0; mem_empty = 1'b0; m_ready = 1'b1;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    rst = 1'b0;
    tick();

    // len=4, free-flowing stream
    base = src_byte;
    start_burst(11'd4);
    check("t1_busy_run", busy, 1);
    wait_done("t1", 40);
    check("t1_busy_at_done", busy, 1);
    check("t1_terr", timeout_err, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_busy_after", busy, 0);
    tick();
    check("t1_done_cnt", done_cnt, 1);
    check("t1_rd_cnt", rd_cnt, 4);
    check("t1_rd_span", last_rd - first_rd, 3);
    check("t1_latency", first_val - first_rd, 2);
    check_bytes("t1", 4, base);
    $display("txn t1 len=4 bytes=%0d done=%0d", got.size(), done_cnt);

    // len=8 with downstream stalled
    base = src_byte;
    m_ready = 1'b0;
    start_burst(11'd8);
    for (int i = 0; i < 10; i++) tick();
    check("t2_rd_stall", rd_cnt, 4);
    check("t2_no_hs", got.size(), 0);
    check("t2_valid_held", m_valid, 1);
    check("t2_data_held", m_data, base);
    m_ready = 1'b1;
    wait_done("t2", 60);
    tick(); tick();
    check("t2_done_cnt", done_cnt, 1);
    check("t2_stable", viol_stable, 0);
    check_bytes("t2", 8, base);
    $display("txn t2 len=8 bytes=%0d done=%0d", got.size(), done_cnt);

    // len=5 with the RAM running empty after the second read
    base = src_byte;
    start_burst(11'd5);
    k = 0;
    while (rd_cnt < 2 && k < 20) begin tick(); k++; end
    check("t3_two_reads", rd_cnt, 2);
    mem_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_no_rd_empty", mem_rd_en, 0);
      tick();
    end
    mem_empty = 1'b0;
    wait_done("t3", 40);
    tick(); tick();
    check("t3_viol_empty", viol_empty, 0);
    check("t3_done_cnt", done_cnt, 1);
    check_bytes("t3", 5, base);
    $display("txn t3 len=5 bytes=%0d done=%0d", got.size(), done_cnt);

    // len=0: empty burst
    start_burst(11'd0);
    check("t4_busy", busy, 1);
    check("t4_no_done_c1", done, 0);
    tick();
    check("t4_done_c2", done, 1);
    tick();
    check("t4_done_c3", done, 0);
    check("t4_busy_c3", busy, 0);
    tick();
    check("t4_rd_cnt", rd_cnt, 0);
    check("t4_no_valid", first_val, 32'hFFFF_FFFF);
    check("t4_done_cnt", done_cnt, 1);
    $display("txn t4 len=0 reads=%0d done=%0d", rd_cnt, done_cnt);

    // reset in the middle of a len=6 burst
    start_burst(11'd6);
    k = 0;
    while (got.size() < 2 && k < 20) begin tick(); k++; end
    check("t5_two_bytes", got.size(), 2);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_rd_en", mem_rd_en, 0);
    check("t5_valid", m_valid, 0);
    check("t5_data", m_data, 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_done", done_cnt, 0);
    base = src_byte;
    start_burst(11'd1);
    wait_done("t5b", 20);
    tick(); tick();
    check("t5b_done_cnt", done_cnt, 1);
    check_bytes("t5b", 1, base);
    $display("txn t5 reset-abort then len=1 bytes=%0d done=%0d", got.size(), done_cnt);

`ifdef DRAIN_TIMEOUT_EN
    // len=3, RAM starves after one byte
    base = src_byte;
    start_burst(11'd3);
    tick();
    mem_empty = 1'b1;
    wait_done("t6", 40);
    check("t6_terr", timeout_err, 1);
    tick();
    check("t6_terr_held", timeout_err, 1);
    check("t6_rd_cnt", rd_cnt, 1);
    check("t6_done_cnt", done_cnt, 1);
    check_bytes("t6", 1, base);
    mem_empty = 1'b0;
    base = src_byte;
    start_burst(11'd1);
    check("t6_terr_clr", timeout_err, 0);
    wait_done("t6b", 20);
    tick(); tick();
    check_bytes("t6b", 1, base);
    $display("txn t6 timeout len=3 then len=1 bytes=%0d", got.size());
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
